mysystem_pio_out_multi: RTL and testbench
=========================================

// Module: mysystem_pio_out_multi
// PURPOSE
//   Parametrised Avalon-MM output PIO: NUM_CH channels of DATA_WIDTH bits each,
//   driving display digits, LEDs and similar outputs from HPS/Nios software.
//   Adds atomic bit set/clear, byte enables, hardware blink masking and a
//   registered read path with fixed latency 1.
//   Sits on the lightweight HPS bridge, one instance per output group.
// PARAMETERS
//   NUM_CH      4          number of output channels (1..16)
//   DATA_WIDTH  32         bits per channel (1..32); upper bus bits read 0, write ignored
//   BLINK_DIV   25000000   clk cycles per blink half-period (>=2)
//   RESET_VAL   0          reset value of every DATA register (DATA_WIDTH bits)
// PORTS
//   clk          in   1                       system clock
//   reset_n      in   1                       async active-low reset
//   address      in   CH_W+2                  {channel, reg}; CH_W=max(1,clog2(NUM_CH))
//   chipselect   in   1                       slave select
//   read_n       in   1                       active-low read strobe
//   write_n      in   1                       active-low write strobe
//   byteenable   in   4                       write byte lanes
//   writedata    in   32                      write data
//   readdata     out  32                      read data, valid 1 cycle after read
//   out_port     out  NUM_CH*DATA_WIDTH       channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   update_pulse out  NUM_CH                  1-cycle pulse when channel DATA changes
// BEHAVIOUR
//   Register map per channel (reg = address[1:0]):
//     0 DATA  R/W  data register
//     1 SET   W    DATA |= wdata (masked by byteenable); reads return DATA
//     2 CLR   W    DATA &= ~wdata (masked by byteenable); reads return DATA
//     3 BLINK R/W  blink mask; set bits blink
//   Write = chipselect & ~write_n; takes effect at that clock edge; no wait states.
//   Byte lane b covers bits [8b+7:8b]; disabled lanes leave register bits unchanged.
//   Channel index >= NUM_CH: writes ignored, reads return 0.
//   Read = chipselect & ~read_n; readdata registered, valid on the next cycle;
//     held until the next read; bits >= DATA_WIDTH read 0.
//   Read and write of the same register in the same cycle: read returns old value.
//   Blink: prescaler 0..BLINK_DIV-1; at terminal count wraps to 0, blink_phase toggles.
//   out_port[c] = DATA[c] & ~(BLINK[c] & {DATA_WIDTH{blink_phase}}); combinational
//     from registers, so a write is visible on out_port the cycle after the edge.
//   Blink timer free-runs; register writes never reset or stall it.
//   update_pulse[c] asserted for exactly the cycle after an edge where DATA[c]
//     changed value; no pulse for a write of the same value or for a BLINK write.
//   Reset (async assert, sync release): DATA=RESET_VAL, BLINK=0, prescaler=0,
//     blink_phase=0 (visible), readdata=0, update_pulse=0, out_port=RESET_VAL.
//   Reset mid-access: access discarded; no partial update.
// STRUCTURE
//   Package mysystem_pio_pkg: register offset constants (REG_DATA/SET/CLR/BLINK),
//     function for byte-lane mask expansion.
//   Sub-module mysystem_pio_blink_timer (BLINK_DIV): prescaler + blink_phase output.
//   Top: channel register arrays, write decode, read mux + readdata register,
//     out_port masking, update_pulse compare registers.
// TESTING
//   1 Reset, NUM_CH=4,DW=8: all out_port=0x00, readdata=0, update_pulse=0.
//   2 Write ch2 DATA=0xA5, be=4'b0001 -> out_port[23:16]=0xA5 next cycle,
//     update_pulse[2] one cycle; read ch2 reg0 -> readdata=0x000000A5 one cycle later.
//   3 ch1 DATA=0xF0; SET 0x0F -> 0xFF; CLR 0x81 -> 0x7E; SET 0x7E again -> no pulse.
//   4 BLINK_DIV=4, ch0 DATA=0xFF, BLINK=0x0F -> out_port[7:0] alternates 0xFF/0xF0
//     every 4 clk; DATA write mid-period does not shift toggle timing.
//   5 DW=8, write 0x12345678 be=4'b1111 to ch0 -> DATA=0x78, readback 0x00000078;
//     write to channel 5 -> no change anywhere, read channel 5 -> 0.
//   6 Assert reset_n low mid-blink and during a write -> all state to reset values
//     immediately; after release blink restarts with phase 0 after BLINK_DIV cycles.

Source files
------------

// File: rtl/mysystem_pio_out_multi_pkg.sv
// Shared definitions for the multi-channel output PIO: register offsets,
// bus widths and the byte-enable expansion helper.
package mysystem_pio_pkg;

    localparam int BUS_W = 32;
    localparam int BE_W  = 4;

    typedef enum logic [1:0] {
        REG_DATA  = 2'd0,
        REG_SET   = 2'd1,
        REG_CLR   = 2'd2,
        REG_BLINK = 2'd3
    } reg_sel_e;

    // Expands each byte-enable bit to cover its 8-bit lane of the bus word.
    function automatic logic [BUS_W-1:0] lane_mask(input logic [BE_W-1:0] be);
        logic [BUS_W-1:0] m;
        m = '0;
        for (int b = 0; b < BE_W; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mysystem_pio_out_multi_if.sv
// Avalon-MM slave bus bundle for the output PIO; address is {channel, reg}.
interface mysystem_pio_out_multi_if
    import mysystem_pio_pkg::*;
#(
    parameter int ADDR_W = 4
) ();

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read_n;
    logic              write_n;
    logic [BE_W-1:0]   byteenable;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;

    modport master (
        output address, chipselect, read_n, write_n, byteenable, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, byteenable, writedata,
        output readdata
    );

endinterface

// File: rtl/mysystem_pio_out_multi_blink_timer.sv
// Free-running blink prescaler: blink_phase toggles every BLINK_DIV clocks
// and is never disturbed by register traffic.
module mysystem_pio_blink_timer #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    output logic blink_phase
);

    localparam int               CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            blink_phase <= 1'b0;
        end else if (count == TERMINAL) begin
            count       <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            count       <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mysystem_pio_out_multi.sv
// Avalon-MM output PIO with per-channel DATA/SET/CLR/BLINK registers,
// hardware blink masking and a one-cycle registered read path.
module mysystem_pio_out_multi
    import mysystem_pio_pkg::*;
#(
    parameter int                    NUM_CH     = 4,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BLINK_DIV  = 25000000,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    mysystem_pio_out_multi_if.slave      avs,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_port,
    output logic [NUM_CH-1:0]            update_pulse
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_WIDTH-1:0] data_q  [NUM_CH];
    logic [DATA_WIDTH-1:0] data_d  [NUM_CH];
    logic [DATA_WIDTH-1:0] blink_q [NUM_CH];
    logic [DATA_WIDTH-1:0] blink_d [NUM_CH];

    logic [CH_W-1:0]       ch_idx;
    reg_sel_e              reg_sel;
    logic                  wr_en;
    logic                  rd_en;
    logic [BUS_W-1:0]      lane_bits;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic [DATA_WIDTH-1:0] wr_bits;
    logic [BUS_W-1:0]      rd_mux;
    logic [BUS_W-1:0]      readdata_q;
    logic                  blink_phase;

    assign ch_idx    = avs.address[CH_W+1:2];
    assign reg_sel   = reg_sel_e'(avs.address[1:0]);
    assign wr_en     = avs.chipselect & ~avs.write_n;
    assign rd_en     = avs.chipselect & ~avs.read_n;
    assign lane_bits = lane_mask(avs.byteenable);
    assign wr_mask   = lane_bits[DATA_WIDTH-1:0];
    assign wr_bits   = avs.writedata[DATA_WIDTH-1:0] & wr_mask;

    // Channel indices with no matching register simply never decode.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            data_d[c]  = data_q[c];
            blink_d[c] = blink_q[c];
            if (wr_en && (ch_idx == CH_W'(c))) begin
                case (reg_sel)
                    REG_DATA:  data_d[c]  = (data_q[c] & ~wr_mask) | wr_bits;
                    REG_SET:   data_d[c]  = data_q[c] | wr_bits;
                    REG_CLR:   data_d[c]  = data_q[c] & ~wr_bits;
                    REG_BLINK: blink_d[c] = (blink_q[c] & ~wr_mask) | wr_bits;
                    default:   data_d[c]  = data_q[c];
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == CH_W'(c)) begin
                rd_mux = (reg_sel == REG_BLINK) ? BUS_W'(blink_q[c]) : BUS_W'(data_q[c]);
            end
        end
    end

    // The read mux looks at the current registers, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                data_q[c]  <= RESET_VAL;
                blink_q[c] <= '0;
            end
            update_pulse <= '0;
            readdata_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                data_q[c]       <= data_d[c];
                blink_q[c]      <= blink_d[c];
                update_pulse[c] <= (data_d[c] != data_q[c]);
            end
            if (rd_en) begin
                readdata_q <= rd_mux;
            end
        end
    end

    assign avs.readdata = readdata_q;

    mysystem_pio_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .blink_phase (blink_phase)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_port[g*DATA_WIDTH +: DATA_WIDTH] =
            data_q[g] & ~(blink_q[g] & {DATA_WIDTH{blink_phase}});
    end

endmodule

// File: tb/tb_mysystem_pio_out_multi.sv
// Scoreboard bench for the output PIO: stimulus queues the expected write and
// read responses, and a monitor process compares them as the DUT presents results.
module tb_mysystem_pio_out_multi;
    import mysystem_pio_pkg::*;

    localparam int NUM_CH     = 5;
    localparam int DATA_WIDTH = 8;
    localparam int BLINK_DIV  = 4;
    localparam int CH_W       = 3;
    localparam int ADDR_W     = CH_W + 2;
    localparam int OUT_W      = NUM_CH * DATA_WIDTH;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [OUT_W-1:0]  out_port;
    logic [NUM_CH-1:0] update_pulse;

    int num_checks = 0;
    int num_fail   = 0;

    logic [DATA_WIDTH-1:0] shadow [NUM_CH];

    string             wr_name_q  [$];
    logic [NUM_CH-1:0] wr_pulse_q [$];
    bit                wr_chk_q   [$];
    logic [OUT_W-1:0]  wr_out_q   [$];
    string             rd_name_q  [$];
    logic [31:0]       rd_exp_q   [$];

    mysystem_pio_out_multi_if #(.ADDR_W(ADDR_W)) bus ();

    mysystem_pio_out_multi #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DATA_WIDTH),
        .BLINK_DIV  (BLINK_DIV),
        .RESET_VAL  (8'h00)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .avs          (bus),
        .out_port     (out_port),
        .update_pulse (update_pulse)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [OUT_W-1:0] packShadow();
        logic [OUT_W-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c*DATA_WIDTH +: DATA_WIDTH] = shadow[c];
        return v;
    endfunction

    // Drives one bus cycle starting at a falling edge and idles the bus at the next one.
    task automatic applyStimulus(input logic [CH_W-1:0] ch, input reg_sel_e rg, input bit do_wr,
                                 input bit do_rd, input logic [31:0] wdata, input logic [3:0] be);
        bus.address    = {ch, rg};
        bus.chipselect = 1'b1;
        bus.write_n    = !do_wr;
        bus.read_n     = !do_rd;
        bus.byteenable = be;
        bus.writedata  = wdata;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
    endtask

    task automatic pushWrite(input string name, input logic [CH_W-1:0] ch, input bit pulse, input bit chk_out);
        logic [NUM_CH-1:0] p;
        p = pulse ? (NUM_CH'(1) << ch) : '0;
        wr_name_q.push_back(name);
        wr_pulse_q.push_back(p);
        wr_chk_q.push_back(chk_out);
        wr_out_q.push_back(packShadow());
    endtask

    task automatic writeExpect(input string name, input logic [CH_W-1:0] ch, input reg_sel_e rg,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [7:0] exp_data, input bit pulse, input bit chk_out);
        if (int'(ch) < NUM_CH && rg != REG_BLINK) shadow[ch] = exp_data;
        pushWrite(name, ch, pulse, chk_out);
        applyStimulus(ch, rg, 1'b1, 1'b0, wdata, be);
    endtask

    task automatic readExpect(input string name, input logic [CH_W-1:0] ch, input reg_sel_e rg,
                              input logic [31:0] exp_data);
        rd_name_q.push_back(name);
        rd_exp_q.push_back(exp_data);
        applyStimulus(ch, rg, 1'b0, 1'b1, 32'h0, 4'h0);
    endtask

    // Monitor: an access seen at a rising edge is checked at the following falling edge.
    initial begin : monitor
        logic              saw_wr;
        logic              saw_rd;
        logic [NUM_CH-1:0] last_pulse;
        logic [NUM_CH-1:0] exp_pulse;
        logic [OUT_W-1:0]  exp_out;
        bit                chk;
        string             nm;
        last_pulse = '0;
        forever begin
            @(posedge clk);
            saw_wr = reset_n && bus.chipselect && !bus.write_n;
            saw_rd = reset_n && bus.chipselect && !bus.read_n;
            @(negedge clk);
            if (!reset_n) begin
                last_pulse = '0;
                continue;
            end
            if (saw_wr) begin
                if (wr_name_q.size() == 0) begin
                    num_checks++;
                    num_fail++;
                    $display("[TB] FAIL write_queue: got empty queue, expected a queued write");
                end else begin
                    nm        = wr_name_q.pop_front();
                    exp_pulse = wr_pulse_q.pop_front();
                    chk       = wr_chk_q.pop_front();
                    exp_out   = wr_out_q.pop_front();
                    checkOutput({nm, "_pulse"}, 64'(update_pulse), 64'(exp_pulse));
                    if (chk) checkOutput({nm, "_out"}, 64'(out_port), 64'(exp_out));
                    last_pulse = exp_pulse;
                end
            end else if (last_pulse != '0) begin
                checkOutput("pulse_clear", 64'(update_pulse), 64'h0);
                last_pulse = '0;
            end
            if (saw_rd) begin
                if (rd_name_q.size() == 0) begin
                    num_checks++;
                    num_fail++;
                    $display("[TB] FAIL read_queue: got empty queue, expected a queued read");
                end else begin
                    nm = rd_name_q.pop_front();
                    checkOutput(nm, 64'(bus.readdata), 64'(rd_exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] prev;
        logic [7:0] v0;
        logic [7:0] exp_data;
        bit         found;
        bit         phase0;
        bit         phase;

        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.byteenable = '0;
        bus.writedata  = '0;
        for (int c = 0; c < NUM_CH; c++) shadow[c] = '0;

        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_out",   64'(out_port),     64'h0);
        checkOutput("rst_pulse", 64'(update_pulse), 64'h0);
        checkOutput("rst_rdata", 64'(bus.readdata), 64'h0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] data write, byte lanes and readback");
        writeExpect("ch2_data",   3'd2, REG_DATA, 32'h0000_00A5, 4'b0001, 8'hA5, 1'b1, 1'b1);
        readExpect ("ch2_rd",     3'd2, REG_DATA, 32'h0000_00A5);
        writeExpect("ch2_be_off", 3'd2, REG_DATA, 32'h0000_0000, 4'b0010, 8'hA5, 1'b0, 1'b1);

        $display("[TB] set / clear");
        writeExpect("ch1_data",     3'd1, REG_DATA, 32'h0000_00F0, 4'b0001, 8'hF0, 1'b1, 1'b1);
        writeExpect("ch1_set",      3'd1, REG_SET,  32'h0000_000F, 4'b0001, 8'hFF, 1'b1, 1'b1);
        writeExpect("ch1_clr",      3'd1, REG_CLR,  32'h0000_0081, 4'b0001, 8'h7E, 1'b1, 1'b1);
        writeExpect("ch1_set_same", 3'd1, REG_SET,  32'h0000_007E, 4'b0001, 8'h7E, 1'b0, 1'b1);
        readExpect ("ch1_rd_set",   3'd1, REG_SET,  32'h0000_007E);
        readExpect ("ch1_rd_clr",   3'd1, REG_CLR,  32'h0000_007E);

        shadow[1] = 8'h11;
        pushWrite("ch1_rw_wr", 3'd1, 1'b1, 1'b1);
        rd_name_q.push_back("ch1_rw_rd_old");
        rd_exp_q.push_back(32'h0000_007E);
        applyStimulus(3'd1, REG_DATA, 1'b1, 1'b1, 32'h0000_0011, 4'b0001);
        readExpect("ch1_rd_new", 3'd1, REG_DATA, 32'h0000_0011);

        $display("[TB] width truncation and out-of-range channel");
        writeExpect("ch0_wide",    3'd0, REG_DATA, 32'h1234_5678, 4'b1111, 8'h78, 1'b1, 1'b1);
        readExpect ("ch0_rd_wide", 3'd0, REG_DATA, 32'h0000_0078);
        writeExpect("ch4_data",    3'd4, REG_DATA, 32'h0000_0099, 4'b0001, 8'h99, 1'b1, 1'b1);
        writeExpect("ch5_ignored", 3'd5, REG_DATA, 32'h0000_00FF, 4'b1111, 8'h00, 1'b0, 1'b1);
        readExpect ("ch5_rd",      3'd5, REG_DATA,  32'h0);
        readExpect ("ch5_rd_blnk", 3'd5, REG_BLINK, 32'h0);

        $display("[TB] blink timing");
        writeExpect("ch0_ff",    3'd0, REG_DATA,  32'h0000_00FF, 4'b0001, 8'hFF, 1'b1, 1'b1);
        writeExpect("ch0_blink", 3'd0, REG_BLINK, 32'h0000_000F, 4'b0001, 8'h00, 1'b0, 1'b0);
        prev  = out_port[7:0];
        found = 1'b0;
        for (int n = 0; n < 3*BLINK_DIV && !found; n++) begin
            @(negedge clk);
            if (out_port[7:0] != prev) found = 1'b1;
        end
        if (!found) begin
            num_checks++;
            num_fail++;
            $display("[TB] FAIL blink_toggle: got no toggle of 0x%0h, expected one within %0d cycles",
                     prev, 3*BLINK_DIV);
        end else begin
            v0     = out_port[7:0];
            phase0 = (v0 == 8'hF0);
            for (int i = 1; i <= 12; i++) begin
                @(negedge clk);
                if (i == 6) begin
                    bus.chipselect = 1'b0;
                    bus.write_n    = 1'b1;
                end
                phase    = phase0 ^ (((i / BLINK_DIV) % 2) == 1);
                exp_data = (i >= 6) ? 8'h3C : 8'hFF;
                checkOutput($sformatf("blink_step%0d", i), 64'(out_port[7:0]),
                            64'(exp_data & ~(8'h0F & {8{phase}})));
                if (i == 5) begin
                    shadow[0] = 8'h3C;
                    pushWrite("ch0_mid_write", 3'd0, 1'b1, 1'b0);
                    bus.address    = {3'd0, REG_DATA};
                    bus.chipselect = 1'b1;
                    bus.write_n    = 1'b0;
                    bus.byteenable = 4'b0001;
                    bus.writedata  = 32'h0000_003C;
                end
            end
        end
        readExpect("ch0_rd_blink", 3'd0, REG_BLINK, 32'h0000_000F);

        $display("[TB] reset during write and blink");
        bus.address    = {3'd3, REG_DATA};
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.byteenable = 4'b0001;
        bus.writedata  = 32'h0000_0055;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst2_out",   64'(out_port),     64'h0);
        checkOutput("rst2_pulse", 64'(update_pulse), 64'h0);
        checkOutput("rst2_rdata", 64'(bus.readdata), 64'h0);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) shadow[c] = '0;
        reset_n = 1'b1;
        writeExpect("post_rst_ff",    3'd0, REG_DATA,  32'h0000_00FF, 4'b0001, 8'hFF, 1'b1, 1'b0);
        writeExpect("post_rst_blink", 3'd0, REG_BLINK, 32'h0000_000F, 4'b0001, 8'h00, 1'b0, 1'b0);
        for (int k = 2; k <= 8; k++) begin
            checkOutput($sformatf("post_rst_phase%0d", k), 64'(out_port[7:0]),
                        64'((k >= BLINK_DIV && k < 2*BLINK_DIV) ? 8'hF0 : 8'hFF));
            if (k < 8) @(negedge clk);
        end
        readExpect("ch3_discarded", 3'd3, REG_DATA, 32'h0);
        readExpect("ch2_after_rst", 3'd2, REG_DATA, 32'h0);

        repeat (3) @(negedge clk);
        checkOutput("wr_queue_empty", 64'(wr_name_q.size()), 64'h0);
        checkOutput("rd_queue_empty", 64'(rd_name_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
